// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the sudoku solver controller.
//   state_t          : sequencer states
//   result_t         : run outcome codes presented on `result`
//   NUM_CELLS/GROUPS : array geometry (81 cells, 9 rows + 9 cols + 9 boxes)
//   group_cell_index : cell index of member m (0..8) of group g (0..26)
package sudoku_pkg;

  localparam int unsigned NUM_CELLS  = 81;
  localparam int unsigned NUM_GROUPS = 27;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    LATCH,
    CHECK
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE     = 2'd0,
    RES_SOLVED   = 2'd1,
    RES_STALLED  = 2'd2,
    RES_CONFLICT = 2'd3
  } result_t;

  // Groups 0..8 are rows, 9..17 columns, 18..26 boxes (row-major boxes,
  // members row-major inside each box).
  function automatic logic [6:0] group_cell_index(input logic [4:0] g,
                                                  input logic [3:0] m);
    logic [6:0] gi;
    logic [6:0] mi;
    logic [6:0] b;
    gi = {2'b00, g};
    mi = {3'b000, m};
    b  = gi - 7'd18;
    if (gi < 7'd9) begin
      return gi * 7'd9 + mi;
    end
    if (gi < 7'd18) begin
      return mi * 7'd9 + (gi - 7'd9);
    end
    return ((b / 7'd3) * 7'd3 + mi / 7'd3) * 7'd9
         + (b % 7'd3) * 7'd3 + mi % 7'd3;
  endfunction

endpackage

// File: rtl/sudoku_group_iter.sv
// Group/member iterator for the propagation passes.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : force group and member back to 0
//   step         : advance member 0..8, wrapping to 0 after 8
//   group_step   : when the member wraps, also advance group (26 wraps to 0)
//   cell_index   : idx(group, member)
//   last_member  : member == 8
//   last_group   : group == 26
module sudoku_group_iter
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       step,
  input  logic       group_step,
  output logic [6:0] cell_index,
  output logic       last_member,
  output logic       last_group
);

  logic [4:0] group;
  logic [3:0] member;

  assign last_member = (member == 4'd8);
  assign last_group  = (group == 5'(NUM_GROUPS - 1));
  assign cell_index  = group_cell_index(group, member);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      group  <= '0;
      member <= '0;
    end else if (clear) begin
      group  <= '0;
      member <= '0;
    end else if (step) begin
      if (last_member) begin
        member <= '0;
        if (group_step) begin
          group <= last_group ? '0 : group + 5'd1;
        end
      end else begin
        member <= member + 4'd1;
      end
    end
  end

endmodule

// File: rtl/sudoku_solver_ctrl.sv
// Sequencer and access arbiter for the 81-cell candidate array.
// Idle: host port passes straight through to the cells. After `start` the
// controller owns the array and runs constraint-propagation passes (read the
// solved values of each group, write the excluded-candidate mask back, latch
// singletons) until solved, conflict, no progress or MAX_PASSES.
//   start/busy/done/result/pass_count : run control and status
//   host_*                            : host register port (dropped while busy)
//   cell_*                            : selected-cell access to the array
//   latch_singleton                   : broadcast latch strobe
//   cell_singleton/solved/illegal     : per-cell status, bit i = cell i
module sudoku_solver_ctrl
  import sudoku_pkg::*;
#(
  parameter int MAX_PASSES = 81
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result,
  output logic [7:0]  pass_count,
  input  logic [6:0]  host_index,
  input  logic        host_addr,
  input  logic        host_we,
  input  logic [9:1]  host_wdata,
  output logic [9:1]  host_rdata,
  output logic [6:0]  cell_index,
  output logic        cell_addr,
  output logic        cell_we,
  output logic [9:1]  cell_wdata,
  input  logic [9:1]  cell_rdata,
  output logic        latch_singleton,
  input  logic [80:0] cell_singleton,
  input  logic [80:0] cell_solved,
  input  logic [80:0] cell_illegal
);

  state_t     state;
  result_t    res_q;
  logic [9:1] mask;
  logic       progress;
  logic [6:0] iter_index;
  logic       last_member;
  logic       last_group;
  logic [7:0] pass_next;

  sudoku_group_iter u_iter (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (state == IDLE),
    .step        ((state == READ) || (state == WRITE)),
    .group_step  (state == WRITE),
    .cell_index  (iter_index),
    .last_member (last_member),
    .last_group  (last_group)
  );

  assign result    = res_q;
  assign pass_next = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;

  // Array port mux: host owns it only while idle.
  always_comb begin
    if (state == IDLE) begin
      cell_index = host_index;
      cell_addr  = host_addr;
      cell_we    = host_we;
      cell_wdata = host_wdata;
      host_rdata = cell_rdata;
    end else begin
      cell_index = iter_index;
      cell_addr  = (state == WRITE);
      cell_we    = (state == WRITE);
      cell_wdata = ~mask;
      host_rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      res_q           <= RES_NONE;
      pass_count      <= '0;
      latch_singleton <= 1'b0;
      mask            <= '0;
      progress        <= 1'b0;
    end else begin
      done            <= 1'b0;
      latch_singleton <= 1'b0;
      unique case (state)
        IDLE: begin
          // `done` is high only in the first idle cycle; a start there is ignored.
          if (start && !done) begin
            state      <= READ;
            busy       <= 1'b1;
            pass_count <= '0;
            res_q      <= RES_NONE;
            mask       <= '0;
          end
        end
        READ: begin
          if (|(mask & cell_rdata)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            res_q <= RES_CONFLICT;
            mask  <= '0;
          end else begin
            mask <= mask | cell_rdata;
            if (last_member) begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (last_member) begin
            mask <= '0;
            if (last_group) begin
              state           <= LATCH;
              latch_singleton <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        LATCH: begin
          progress <= |(cell_singleton & ~cell_solved);
          state    <= CHECK;
        end
        CHECK: begin
          pass_count <= pass_next;
          if (|cell_illegal) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            res_q <= RES_CONFLICT;
          end else if (&cell_solved) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            res_q <= RES_SOLVED;
          end else if (!progress || (int'(pass_count) + 1 == MAX_PASSES)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            res_q <= RES_STALLED;
          end else begin
            state <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_solver_ctrl.sv
// Directed self-checking bench for sudoku_solver_ctrl with a behavioural
// 81-cell array: value (one-hot [9:1], 0 = unsolved) and candidate mask.
// Value write sets mask to the value (all ones when 0); mask write ANDs in.
module tb_sudoku_solver_ctrl;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  result;
  logic [7:0]  pass_count;
  logic [6:0]  host_index;
  logic        host_addr;
  logic        host_we;
  logic [9:1]  host_wdata;
  logic [9:1]  host_rdata;
  logic [6:0]  cell_index;
  logic        cell_addr;
  logic        cell_we;
  logic [9:1]  cell_wdata;
  logic [9:1]  cell_rdata;
  logic        latch_singleton;
  logic [80:0] cell_singleton;
  logic [80:0] cell_solved;
  logic [80:0] cell_illegal;

  int tests_run;
  int tests_failed;

  sudoku_solver_ctrl #(.MAX_PASSES(81)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .result          (result),
    .pass_count      (pass_count),
    .host_index      (host_index),
    .host_addr       (host_addr),
    .host_we         (host_we),
    .host_wdata      (host_wdata),
    .host_rdata      (host_rdata),
    .cell_index      (cell_index),
    .cell_addr       (cell_addr),
    .cell_we         (cell_we),
    .cell_wdata      (cell_wdata),
    .cell_rdata      (cell_rdata),
    .latch_singleton (latch_singleton),
    .cell_singleton  (cell_singleton),
    .cell_solved     (cell_solved),
    .cell_illegal    (cell_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell array model
  logic [8:0] val  [81];
  logic [8:0] cand [81];

  always_ff @(posedge clk) begin
    if (cell_we && cell_index < 7'd81) begin
      if (cell_addr) begin
        cand[cell_index] <= cand[cell_index] & cell_wdata;
      end else begin
        val[cell_index]  <= cell_wdata;
        cand[cell_index] <= (cell_wdata == 9'd0) ? 9'h1FF : cell_wdata;
      end
    end
    if (latch_singleton) begin
      for (int i = 0; i < 81; i++) begin
        if (val[i] == 9'd0 && $countones(cand[i]) == 1) val[i] <= cand[i];
      end
    end
  end

  always_comb begin
    cell_rdata = '0;
    if (cell_index < 7'd81) cell_rdata = cell_addr ? cand[cell_index] : val[cell_index];
    for (int i = 0; i < 81; i++) begin
      cell_solved[i]    = (val[i] != 9'd0);
      cell_singleton[i] = ($countones(cand[i]) == 1);
      cell_illegal[i]   = (val[i] == 9'd0) && (cand[i] == 9'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int idx, input logic a, input logic [8:0] d);
    host_index = 7'(idx);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    tick();
    host_we    = 1'b0;
  endtask

  // Valid solved grid: value(r,c) = ((3r + r/3 + c) mod 9) + 1
  function automatic logic [8:0] sol(input int idx);
    int r;
    int c;
    int v;
    r = idx / 9;
    c = idx % 9;
    v = (r * 3 + r / 3 + c) % 9 + 1;
    return 9'(1) << (v - 1);
  endfunction

  task automatic load_solved();
    for (int i = 0; i < 81; i++) host_write(i, 1'b0, sol(i));
  endtask

  task automatic load_empty();
    for (int i = 0; i < 81; i++) host_write(i, 1'b0, 9'd0);
  endtask

  // Pulse start; returns positioned in cycle 1 of the run.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n, output logic we_seen);
    n = n0;
    we_seen = 1'b0;
    while (!done && n < 3000) begin
      if (cell_we) we_seen = 1'b1;
      tick();
      n++;
    end
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  int         cyc;
  logic       we_seen;
  logic [8:0] rd;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    host_index = '0;
    host_addr  = 1'b0;
    host_we    = 1'b0;
    host_wdata = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_pass_count", 32'(pass_count), 32'd0);
    check("rst_latch", 32'(latch_singleton), 32'd0);
    check("rst_cell_we", 32'(cell_we), 32'd0);
    reset_n = 1'b1;
    tick();

    // 1) solved grid, plus host access attempts while busy
    load_solved();
    host_index = 7'd0;
    host_addr  = 1'b0;
    #1;
    check("idle_passthrough_rd", 32'(host_rdata), 32'h001);
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("rdata_zero_busy", 32'(host_rdata), 32'd0);
    host_write(0, 1'b0, 9'h100);
    check("rdata_zero_busy2", 32'(host_rdata), 32'd0);
    wait_done(2, cyc, we_seen);
    check("solved_done_cycle", 32'(cyc), 32'd489);
    check("solved_result", 32'(result), 32'd1);
    check("solved_pass_count", 32'(pass_count), 32'd1);
    check("solved_busy_clear", 32'(busy), 32'd0);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("result_held", 32'(result), 32'd1);
    host_index = 7'd0;
    host_addr  = 1'b0;
    #1;
    check("busy_write_dropped", 32'(host_rdata), 32'h001);

    // 2) cell 40 cleared: recovered by one pass (value 9 -> bit 9)
    load_solved();
    host_write(40, 1'b0, 9'd0);
    pulse_start();
    wait_done(1, cyc, we_seen);
    check("c40_done_cycle", 32'(cyc), 32'd489);
    check("c40_result", 32'(result), 32'd1);
    check("c40_pass_count", 32'(pass_count), 32'd1);
    host_index = 7'd40;
    host_addr  = 1'b0;
    #1;
    rd = host_rdata;
    check("c40_value", 32'(rd), 32'h100);

    // 3) duplicate 1 in cells 0 and 5: read of m=5 in cycle 6, done in cycle 7
    load_empty();
    host_write(0, 1'b0, 9'h001);
    host_write(5, 1'b0, 9'h001);
    pulse_start();
    wait_done(1, cyc, we_seen);
    check("conf_done_cycle", 32'(cyc), 32'd7);
    check("conf_result", 32'(result), 32'd3);
    check("conf_no_write", 32'(we_seen), 32'd0);
    check("conf_pass_count", 32'(pass_count), 32'd0);

    // 4) empty grid: stalled after one pass; start during done is ignored
    load_empty();
    pulse_start();
    wait_done(1, cyc, we_seen);
    check("empty_done_cycle", 32'(cyc), 32'd489);
    check("empty_result", 32'(result), 32'd2);
    check("empty_pass_count", 32'(pass_count), 32'd1);
    pulse_start();
    check("start_on_done_ignored", 32'(busy), 32'd0);
    check("start_on_done_result", 32'(result), 32'd2);

    // 5) reset at cycle 200, then a fresh run
    pulse_start();
    for (int i = 1; i < 200; i++) tick();
    check("mid_run_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_cell_we", 32'(cell_we), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_start();
    wait_done(1, cyc, we_seen);
    check("post_rst_done_cycle", 32'(cyc), 32'd489);
    check("post_rst_result", 32'(result), 32'd2);
    check("post_rst_pass_count", 32'(pass_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
